ant_switch_allocator: RTL and testbench
=======================================

Name: ant_switch_allocator

Overview:
- Per-router switch allocator that sits directly downstream of the ant routing agent.
- Consumes the agent's per-input one-hot output requests and resolves contention with one round-robin arbiter per output port.
- Tracks downstream buffer credits per output port.
- Issues registered grants that drive the crossbar select lines and the input-buffer dequeue strobes.

Parameters:
- N, `N (5): number of input ports.
- M, `M (5): number of output ports. Bit 4 is local ejection; bits 3..0 are the mesh directions.
- CREDITS, 4: downstream buffer depth per output, which is the initial and maximum credit count.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_output_req  input  [0:N-1][M-1:0]  per-input output request from the routing agent. One-hot; all-zero means no request.
- i_credit_return  input  [M-1:0]  one credit returned for output j this cycle.
- o_grant  output  [0:N-1][M-1:0]  registered; input i was granted output j.
- o_input_ack  output  [0:N-1]  registered; OR-reduction of o_grant[i]. The input dequeues its packet.
- o_output_val  output  [M-1:0]  registered; output j carries a granted packet this cycle.
- o_output_sel  output  [0:M-1][$clog2(N)-1:0]  registered; winning input index for output j. Value is 0 when o_output_val[j]=0.
- o_credit_count  output  [0:M-1][$clog2(CREDITS+1)-1:0]  current credit count per output.
- o_req_error  output  [0:N-1]  registered; input i presented a request with more than one bit set.
- o_credit_err  output  [M-1:0]  registered; credit returned while the count was already CREDITS.

Behaviour:

Reset values:
- All o_* outputs are 0, except o_credit_count[j] = CREDITS.
- rr_ptr[j] = 0.
- Reset asserted mid-operation discards any pending grants on the next edge.
- No grant is issued in the cycle after a reset cycle.

Request qualification (combinational, cycle t):
- Input i requests output j iff i_output_req[i] == (1<<j).
- If popcount(i_output_req[i]) > 1, the request is ignored and o_req_error[i]=1 at t+1.
- Mask: if o_input_ack[i]=1 at cycle t, input i's request is ignored in cycle t. This covers the cycle in which the input is still presenting its just-granted packet and prevents a double grant.

Eligibility:
- Output j may be granted only if o_credit_count[j] > 0.
- A credit returned in cycle t does not enable a grant in cycle t.

Arbitration (per output j, independent):
- Scan inputs rr_ptr[j], rr_ptr[j]+1, ... modulo N. The first qualified requester wins.
- After a grant, rr_ptr[j] <= (winner+1) mod N.
- With no grant, rr_ptr[j] is unchanged.
- Each input requests at most one output, so each input receives at most one grant per cycle.

Latency:
- A request at edge t produces o_grant, o_input_ack, o_output_val and o_output_sel at t+1.
- These outputs are high for exactly one cycle per grant.

Credit counter (per output j):
- count_next = count - grant_j + return_j, evaluated at the same edge as the grant registers.
- A simultaneous grant and return leaves the count unchanged.
- If return_j=1 while count==CREDITS and no grant occurs: count holds at CREDITS, the return is dropped, and o_credit_err[j]=1 for one cycle.
- A grant when count==0 is impossible by construction (eligibility rule).

Outputs that must not toggle:
- o_grant and o_output_sel for an output change only on a grant.
- Otherwise o_output_val=0 and o_output_sel=0.

Test Plan:
- Reset: hold i_reset 3 cycles with random requests -> all grants 0, o_credit_count = 4,4,4,4,4. On the first cycle after reset, still no grant.
- Single request: i_output_req[0]=5'b00100 at cycle t, dropped on ack -> at t+1 o_grant[0]=5'b00100, o_input_ack[0]=1, o_output_val[2]=1, o_output_sel[2]=0. Then o_credit_count[2]=3; exactly one grant.
- Contention: inputs 1 and 3 hold 5'b10000 and re-request after each ack, with credits returned each cycle -> output 4 grants go 1,3,1,3. rr_ptr[4] alternates 2,4. No input is granted twice in consecutive cycles.
- Credit exhaustion: input 0 holds 5'b00001, no returns -> 4 grants on alternate cycles, then stall with o_credit_count[0]=0. Pulse i_credit_return[0] once -> exactly one more grant, issued no earlier than the cycle after the return.
- Boundaries:
  - count[1]=1 with a grant and i_credit_return[1] in the same cycle -> count stays 1.
  - Return at count=4 with no grant -> count stays 4, o_credit_err[1]=1 for one cycle.
- Illegal request and mid-operation reset:
  - i_output_req[2]=5'b00110 -> o_req_error[2]=1 at t+1, no grant, pointers unchanged.
  - Assert i_reset during active traffic -> next cycle all outputs 0 and counts at 4.

Source files
------------

// File: rtl/ant_switch_allocator.sv
// Switch allocator for the ant router: one round-robin arbiter per output port,
// gated by downstream credits, producing registered crossbar grants.
module ant_switch_allocator #(
    parameter int N       = 5,
    parameter int M       = 5,
    parameter int CREDITS = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [0:N-1][M-1:0]                    i_output_req,
    input  logic [M-1:0]                           i_credit_return,
    output logic [0:N-1][M-1:0]                    o_grant,
    output logic [0:N-1]                           o_input_ack,
    output logic [M-1:0]                           o_output_val,
    output logic [0:M-1][$clog2(N)-1:0]            o_output_sel,
    output logic [0:M-1][$clog2(CREDITS+1)-1:0]    o_credit_count,
    output logic [0:N-1]                           o_req_error,
    output logic [M-1:0]                           o_credit_err
);

    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [0:N-1]              req_vld_p0;
    logic [0:N-1]              req_err_p0;
    logic [0:N-1][M-1:0]       grant_p0;
    logic [M-1:0]              out_vld_p0;
    logic [0:M-1][SEL_W-1:0]   out_sel_p0;
    logic [0:M-1][SEL_W-1:0]   rr_ptr;
    logic [0:M-1][CNT_W-1:0]   credit_cnt;

    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] winner);
        return (winner == SEL_W'(N - 1)) ? '0 : winner + 1'b1;
    endfunction

    // A return arriving at a full counter is dropped; the error flag reports it.
    function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] cnt,
                                                     input logic gnt,
                                                     input logic ret);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (gnt && !ret)
            res = cnt - 1'b1;
        else if (!gnt && ret && cnt != CNT_W'(CREDITS))
            res = cnt + 1'b1;
        return res;
    endfunction

    // Inputs whose grant is still visible are masked to avoid a double grant.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_err_p0[i] = ($countones(i_output_req[i]) > 1);
            req_vld_p0[i] = $onehot(i_output_req[i]) && !o_input_ack[i];
        end
    end

    always_comb begin
        logic [SEL_W-1:0] idx;
        int               sum;
        grant_p0   = '0;
        out_vld_p0 = '0;
        out_sel_p0 = '0;
        idx        = '0;
        sum        = 0;
        for (int j = 0; j < M; j++) begin
            if (credit_cnt[j] != '0) begin
                for (int k = 0; k < N; k++) begin
                    sum = int'(rr_ptr[j]) + k;
                    if (sum >= N)
                        sum = sum - N;
                    idx = SEL_W'(sum);
                    if (!out_vld_p0[j] && req_vld_p0[idx] && i_output_req[idx][j]) begin
                        out_vld_p0[j]      = 1'b1;
                        out_sel_p0[j]      = idx;
                        grant_p0[idx][j]   = 1'b1;
                    end
                end
            end
        end
    end

    // ---- stage boundary: registered grants, pointers and credits ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_grant      <= '0;
            o_input_ack  <= '0;
            o_output_val <= '0;
            o_output_sel <= '0;
            o_req_error  <= '0;
            o_credit_err <= '0;
            rr_ptr       <= '0;
            for (int j = 0; j < M; j++)
                credit_cnt[j] <= CNT_W'(CREDITS);
        end else begin
            o_grant      <= grant_p0;
            o_output_val <= out_vld_p0;
            o_output_sel <= out_sel_p0;
            o_req_error  <= req_err_p0;
            for (int i = 0; i < N; i++)
                o_input_ack[i] <= |grant_p0[i];
            for (int j = 0; j < M; j++) begin
                credit_cnt[j]   <= credit_next(credit_cnt[j], out_vld_p0[j], i_credit_return[j]);
                o_credit_err[j] <= i_credit_return[j] && !out_vld_p0[j] &&
                                   (credit_cnt[j] == CNT_W'(CREDITS));
                if (out_vld_p0[j])
                    rr_ptr[j] <= ptr_next(out_sel_p0[j]);
            end
        end
    end

    assign o_credit_count = credit_cnt;

endmodule

// File: tb/tb_ant_switch_allocator.sv
// Randomised and directed bench for ant_switch_allocator against a cycle-level
// reference model of round-robin allocation with credit accounting.
module tb_ant_switch_allocator;

    localparam int N       = 5;
    localparam int M       = 5;
    localparam int CREDITS = 4;
    localparam int SW      = $clog2(N);
    localparam int CW      = $clog2(CREDITS + 1);

    logic                     clk;
    logic                     rst;
    logic [0:N-1][M-1:0]      req;
    logic [M-1:0]             ret;
    logic [0:N-1][M-1:0]      o_grant;
    logic [0:N-1]             o_input_ack;
    logic [M-1:0]             o_output_val;
    logic [0:M-1][SW-1:0]     o_output_sel;
    logic [0:M-1][CW-1:0]     o_credit_count;
    logic [0:N-1]             o_req_error;
    logic [M-1:0]             o_credit_err;

    logic [0:N-1][M-1:0]      exp_grant;
    logic [0:N-1]             exp_ack;
    logic [M-1:0]             exp_val;
    logic [0:M-1][SW-1:0]     exp_sel;
    logic [0:M-1][CW-1:0]     exp_cnt;
    logic [0:N-1]             exp_rerr;
    logic [M-1:0]             exp_cerr;

    int m_cnt[M];
    int m_ptr[M];
    bit m_ack[N];

    int n_checks = 0;
    int n_fail   = 0;

    ant_switch_allocator #(.N(N), .M(M), .CREDITS(CREDITS)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_output_req    (req),
        .i_credit_return (ret),
        .o_grant         (o_grant),
        .o_input_ack     (o_input_ack),
        .o_output_val    (o_output_val),
        .o_output_sel    (o_output_sel),
        .o_credit_count  (o_credit_count),
        .o_req_error     (o_req_error),
        .o_credit_err    (o_credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected result of the coming clock edge, from the allocation rules.
    task automatic model_step();
        bit vld[N];
        int win, idx, pc;
        exp_grant = '0; exp_ack = '0; exp_val = '0; exp_sel = '0;
        exp_rerr  = '0; exp_cerr = '0;
        if (rst) begin
            for (int j = 0; j < M; j++) begin
                m_cnt[j] = CREDITS;
                m_ptr[j] = 0;
            end
            for (int i = 0; i < N; i++) m_ack[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                pc          = $countones(req[i]);
                vld[i]      = (pc == 1) && !m_ack[i];
                exp_rerr[i] = (pc > 1);
            end
            for (int j = 0; j < M; j++) begin
                win = -1;
                if (m_cnt[j] > 0)
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr[j] + k) % N;
                        if (win < 0 && vld[idx] && req[idx] == (M'(1) << j)) win = idx;
                    end
                if (win >= 0) begin
                    exp_grant[win][j] = 1'b1;
                    exp_val[j]        = 1'b1;
                    exp_sel[j]        = SW'(win);
                    m_ptr[j]          = (win + 1) % N;
                end
                if (win >= 0 && !ret[j]) m_cnt[j] = m_cnt[j] - 1;
                else if (win < 0 && ret[j]) begin
                    if (m_cnt[j] == CREDITS) exp_cerr[j] = 1'b1;
                    else m_cnt[j] = m_cnt[j] + 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                m_ack[i]   = |exp_grant[i];
                exp_ack[i] = m_ack[i];
            end
        end
        for (int j = 0; j < M; j++) exp_cnt[j] = CW'(m_cnt[j]);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("grant",      64'(o_grant),        64'(exp_grant));
        chk("input_ack",  64'(o_input_ack),    64'(exp_ack));
        chk("output_val", 64'(o_output_val),   64'(exp_val));
        chk("output_sel", 64'(o_output_sel),   64'(exp_sel));
        chk("credits",    64'(o_credit_count), 64'(exp_cnt));
        chk("req_error",  64'(o_req_error),    64'(exp_rerr));
        chk("credit_err", 64'(o_credit_err),   64'(exp_cerr));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) step();
        rst = 1'b0;
    endtask

    function automatic logic [M-1:0] rand_req();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return '0;
        if (r < 9) return M'(1) << $urandom_range(0, M - 1);
        return M'($urandom);
    endfunction

    initial begin
        int seq[$];
        int gcount;
        rst = 1'b1;
        req = '0;
        ret = '0;

        // Reset with random requests present
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) req[i] = rand_req();
            step();
        end
        chk("reset_cnt", 64'(o_credit_count), 64'({CW'(4), CW'(4), CW'(4), CW'(4), CW'(4)}));
        rst = 1'b0;
        req = '0;
        step();
        chk("post_reset_grant", 64'(o_grant), 64'd0);

        // Single request, dropped once acknowledged
        req[0] = 5'b00100;
        step();
        chk("single_grant", 64'(o_grant[0]), 64'(5'b00100));
        chk("single_sel",   64'(o_output_sel[2]), 64'd0);
        req[0] = '0;
        step();
        chk("single_cnt", 64'(o_credit_count[2]), 64'd3);
        chk("single_once", 64'(o_grant), 64'd0);

        // Contention on the ejection port with steady credit return
        do_reset(2);
        req[1] = 5'b10000;
        req[3] = 5'b10000;
        ret    = 5'b10000;
        for (int c = 0; c < 6; c++) begin
            step();
            if (o_output_val[4]) seq.push_back(int'(o_output_sel[4]));
        end
        chk("contention_len", 64'(seq.size()), 64'd6);
        chk("contention_0", 64'(seq[0]), 64'd1);
        chk("contention_1", 64'(seq[1]), 64'd3);
        chk("contention_2", 64'(seq[2]), 64'd1);
        chk("contention_3", 64'(seq[3]), 64'd3);
        req = '0;
        ret = '0;

        // Credit exhaustion and a single replenishing return
        do_reset(2);
        req[0] = 5'b00001;
        gcount = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (o_grant[0][0]) gcount++;
        end
        chk("exhaust_grants", 64'(gcount), 64'd4);
        chk("exhaust_cnt", 64'(o_credit_count[0]), 64'd0);
        ret[0] = 1'b1;
        step();
        chk("return_same_cycle", 64'(o_grant[0]), 64'd0);
        ret[0] = 1'b0;
        gcount = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (o_grant[0][0]) gcount++;
        end
        chk("replenish_grants", 64'(gcount), 64'd1);
        req = '0;

        // Grant and return together at count 1; return into a full counter
        do_reset(2);
        req[0] = 5'b00010;
        for (int c = 0; c < 6; c++) step();
        chk("bnd_cnt1", 64'(o_credit_count[1]), 64'd1);
        ret[1] = 1'b1;
        step();
        chk("bnd_grant", 64'(o_grant[0]), 64'(5'b00010));
        chk("bnd_hold", 64'(o_credit_count[1]), 64'd1);
        req = '0;
        ret = '0;
        do_reset(2);
        ret[1] = 1'b1;
        step();
        chk("full_err", 64'(o_credit_err[1]), 64'd1);
        chk("full_cnt", 64'(o_credit_count[1]), 64'd4);
        ret[1] = 1'b0;
        step();
        chk("full_err_pulse", 64'(o_credit_err[1]), 64'd0);

        // Illegal multi-hot request
        req[2] = 5'b00110;
        step();
        chk("illegal_err", 64'(o_req_error[2]), 64'd1);
        chk("illegal_nogrant", 64'(o_grant), 64'd0);
        req = '0;
        step();

        // Random traffic with occasional mid-operation resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) req[i] = rand_req();
            ret = M'($urandom) & M'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            step();
            if (rst) chk("midreset_cnt", 64'(o_credit_count), 64'({CW'(4), CW'(4), CW'(4), CW'(4), CW'(4)}));
        end

        // Reset during active traffic
        for (int i = 0; i < N; i++) req[i] = M'(1) << i;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midreset_grant", 64'(o_grant), 64'd0);
        chk("midreset_val", 64'(o_output_val), 64'd0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
